// File: rtl/security_lane_arbiter.sv
// security_lane_arbiter
// Arbitrates three passenger classes (VIP, crew, regular) onto one baggage
// scanner. VIP outranks crew, and crew outranks regular. A regular request
// that has lost AGE_LIMIT arbitrations in a row is served next.
// Optional build macro SCAN_TIMEOUT_EN: a scan is aborted after TIMEOUT
// SCAN-state cycles without scan_done, and timeout_err pulses in RELEASE.
// AGE_LIMIT must fit the 3-bit age counter (<= 7).
// TIMEOUT must fit the 5-bit scan counter (<= 31).
module security_lane_arbiter #(
    parameter int AGE_LIMIT = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] bag_data,
    input  logic       scan_done,
    output logic [2:0] grant,
    output logic       scan_start,
    output logic [7:0] scan_data,
    output logic       busy,
    output logic       parity,
    output logic       starve_flag,
    output logic [7:0] served_count,
    output logic       timeout_err
);
    localparam logic [2:0] AGE_MAX = 3'(AGE_LIMIT);
    localparam logic [4:0] TO_MAX  = 5'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT, SCAN, RELEASE} state_t;

    state_t     state_reg;
    logic [2:0] age_reg;
    logic [2:0] winner;
    logic [2:0] age_next;

`ifdef SCAN_TIMEOUT_EN
    logic [4:0] scan_cnt_reg;
`else
    // Without the timeout build the limit is meaningless; keep it referenced.
    logic unused_timeout;
    assign unused_timeout = ^TO_MAX;
    assign timeout_err    = 1'b0;
`endif

    // Winner among the requests sampled in IDLE; a starved regular request preempts all
    always_comb begin
        winner = 3'b000;
        if ((age_reg == AGE_MAX) && req[0])
            winner = 3'b001;
        else if (req[2])
            winner = 3'b100;
        else if (req[1])
            winner = 3'b010;
        else if (req[0])
            winner = 3'b001;
    end

    // Regular-class age: grows (saturating) only while regular requests and loses
    always_comb begin
        age_next = 3'd0;
        if (req[0] && !winner[0])
            age_next = (age_reg >= AGE_MAX) ? AGE_MAX : age_reg + 3'd1;
    end

    // Arbitration FSM; every output is a register updated with the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            age_reg      <= 3'd0;
            grant        <= 3'b000;
            scan_start   <= 1'b0;
            scan_data    <= 8'h00;
            busy         <= 1'b0;
            parity       <= 1'b0;
            starve_flag  <= 1'b0;
            served_count <= 8'h00;
`ifdef SCAN_TIMEOUT_EN
            scan_cnt_reg <= 5'd0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            scan_start <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (req != 3'b000) begin
                        state_reg   <= GRANT;
                        grant       <= winner;
                        scan_data   <= bag_data;
                        parity      <= ^bag_data;
                        scan_start  <= 1'b1;
                        busy        <= 1'b1;
                        age_reg     <= age_next;
                        starve_flag <= (age_next == AGE_MAX);
                    end
                end
                GRANT: begin
                    state_reg <= SCAN;
`ifdef SCAN_TIMEOUT_EN
                    scan_cnt_reg <= 5'd0;
`endif
                end
                SCAN: begin
                    // scan_done wins over a timeout that expires in the same cycle
                    if (scan_done) begin
                        state_reg    <= RELEASE;
                        grant        <= 3'b000;
                        served_count <= served_count + 8'd1;
                    end
`ifdef SCAN_TIMEOUT_EN
                    else if (scan_cnt_reg == TO_MAX) begin
                        state_reg   <= RELEASE;
                        grant       <= 3'b000;
                        timeout_err <= 1'b1;
                    end else begin
                        scan_cnt_reg <= scan_cnt_reg + 5'd1;
                    end
`endif
                end
                RELEASE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    grant     <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_security_lane_arbiter.sv
// Testbench for security_lane_arbiter: transaction-level reference model checked
// every cycle, plus directed literal checks and a randomized wrap-around run.
module tb_security_lane_arbiter;
    localparam int AGE_P = 4;
    localparam int TO_P  = 16;
`ifdef SCAN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] req = 3'b000;
    logic [7:0] bag_data = 8'h00;
    logic       scan_done = 1'b0;
    logic [2:0] grant;
    logic       scan_start;
    logic [7:0] scan_data;
    logic       busy;
    logic       parity;
    logic       starve_flag;
    logic [7:0] served_count;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;
    int txn_id = 0;

    always #5 clk = ~clk;

    security_lane_arbiter #(.AGE_LIMIT(AGE_P), .TIMEOUT(TO_P)) dut (
        .clk(clk), .reset(reset), .req(req), .bag_data(bag_data),
        .scan_done(scan_done), .grant(grant), .scan_start(scan_start),
        .scan_data(scan_data), .busy(busy), .parity(parity),
        .starve_flag(starve_flag), .served_count(served_count),
        .timeout_err(timeout_err)
    );

    // ---------------- reference model ----------------
    // m_pos: -1 idle, 0 grant cycle, 1 scanning, 2 release cycle
    int         m_pos = -1;
    int         m_age = 0;
    int         m_scan = 0;
    int         m_served = 0;
    logic [2:0] m_grant = 3'b000;
    logic       m_start = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_par = 1'b0;
    logic       m_tout = 1'b0;
    bit         m_valid = 1'b0;

    // class index served for request vector r given the current age
    function automatic int pick(input logic [2:0] r, input int age);
        if (age == AGE_P && r[0]) return 0;
        for (int i = 2; i >= 0; i--)
            if (r[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pos <= -1; m_age <= 0; m_scan <= 0; m_served <= 0;
            m_grant <= 3'b000; m_start <= 1'b0; m_data <= 8'h00;
            m_par <= 1'b0; m_tout <= 1'b0; m_valid <= 1'b1;
        end else begin
            m_start <= 1'b0;
            m_tout  <= 1'b0;
            if (m_pos == -1) begin
                if (req != 3'b000) begin
                    m_grant <= 3'(32'd1 << pick(req, m_age));
                    m_age   <= (!req[0] || pick(req, m_age) == 0) ? 0 :
                               ((m_age + 1 > AGE_P) ? AGE_P : m_age + 1);
                    m_data  <= bag_data;
                    m_par   <= (($countones(bag_data) % 2) == 1);
                    m_start <= 1'b1;
                    m_pos   <= 0;
                end
            end else if (m_pos == 0) begin
                m_pos  <= 1;
                m_scan <= 0;
            end else if (m_pos == 1) begin
                if (scan_done) begin
                    m_pos <= 2; m_grant <= 3'b000; m_served <= (m_served + 1) % 256;
                end else if (TO_EN && m_scan == TO_P) begin
                    m_pos <= 2; m_grant <= 3'b000; m_tout <= 1'b1;
                end else begin
                    m_scan <= m_scan + 1;
                end
            end else begin
                m_pos <= -1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        if (m_valid && reset)
            chk("cycle {grant,start,data,busy,par,starve,served,tout}",
                32'({grant, scan_start, scan_data, busy, parity, starve_flag, served_count, timeout_err}),
                32'({m_grant, m_start, m_data, (m_pos != -1), m_par, (m_age == AGE_P), 8'(m_served), m_tout}));
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("idle_wait busy", 32'(busy), 32'd0);
    endtask

    // One scanner transaction: request, wait for scan_start, swap req to mid
    // during the scan, pulse scan_done d cycles after start with req -> end_r.
    task automatic txn(input logic [2:0] r, input logic [7:0] b, input int d,
                       input logic [2:0] mid, input logic [2:0] end_r, input bit idle_after,
                       output logic [2:0] g, output logic st, output logic [7:0] sd,
                       output logic p, output logic [2:0] g_late);
        bit ok = 1'b0;
        @(negedge clk);
        req = r; bag_data = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (scan_start) ok = 1'b1;
        end
        g = grant; st = starve_flag; sd = scan_data; p = parity; g_late = grant;
        if (!ok) begin
            chk("scan_start_wait", 32'(scan_start), 32'd1);
            return;
        end
        txn_id++;
        $display("[TB] txn %0d req=%b grant=%b data=%02h parity=%b starve=%b served=%0d",
                 txn_id, r, g, sd, p, st, served_count);
        req = mid;
        repeat (d) @(negedge clk);
        g_late = grant;
        scan_done = 1'b1; req = end_r;
        @(negedge clk);
        scan_done = 1'b0;
        if (idle_after) wait_idle();
    endtask

    logic [2:0] g, gl;
    logic       st, p;
    logic [7:0] sd;
    logic [2:0] gs [5];
    logic       sts [5];

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset served", 32'(served_count), 32'd0);
        chk("reset scan_data", 32'(scan_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single VIP transaction with AAh
        txn(3'b100, 8'hAA, 3, 3'b000, 3'b000, 1'b1, g, st, sd, p, gl);
        chk("vip grant", 32'(g), 32'h4);
        chk("vip scan_data", 32'(sd), 32'hAA);
        chk("vip parity", 32'(p), 32'd0);
        chk("vip served", 32'(served_count), 32'd1);
        chk("vip busy after release", 32'(busy), 32'd0);

        // All classes requesting continuously: VIP x4, then forced regular
        for (int k = 0; k < 5; k++) begin
            txn(3'b111, 8'(8'h10 + k), 1, 3'b111, 3'b111, 1'b0, g, st, sd, p, gl);
            gs[k] = g; sts[k] = st;
        end
        req = 3'b000;
        wait_idle();
        for (int k = 0; k < 4; k++) chk("starve vip grant", 32'(gs[k]), 32'h4);
        chk("starve flag grant1", 32'(sts[0]), 32'd0);
        chk("starve flag grant4", 32'(sts[3]), 32'd1);
        chk("starve regular grant5", 32'(gs[4]), 32'h1);
        chk("starve flag cleared grant5", 32'(sts[4]), 32'd0);

        // Crew grant held while req changes to regular during the scan
        txn(3'b010, 8'h55, 3, 3'b001, 3'b001, 1'b0, g, st, sd, p, gl);
        chk("crew grant", 32'(g), 32'h2);
        chk("crew grant held in scan", 32'(gl), 32'h2);
        txn(3'b001, 8'h66, 2, 3'b000, 3'b000, 1'b1, g, st, sd, p, gl);
        chk("regular after crew", 32'(g), 32'h1);
        chk("regular scan_data", 32'(sd), 32'h66);
        chk("regular parity", 32'(p), 32'd0);

`ifdef SCAN_TIMEOUT_EN
        // Scan with no scan_done: aborts 17 cycles after entering SCAN
        begin
            logic [7:0] served_before;
            int n;
            bit seen;
            served_before = served_count;
            @(negedge clk);
            req = 3'b001; bag_data = 8'h01;
            for (int i = 0; i < 20 && !scan_start; i++) @(negedge clk);
            req = 3'b000;
            n = 0; seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                n++;
                if (timeout_err) seen = 1'b1;
            end
            chk("timeout cycles from grant", 32'(n), 32'd18);
            chk("timeout served unchanged", 32'(served_count), 32'(served_before));
            @(negedge clk);
            chk("timeout pulse width", 32'(timeout_err), 32'd0);
            chk("timeout back to idle", 32'(busy), 32'd0);
        end
`endif

        // Reset mid-scan after five completed scans
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++)
            txn(3'(k % 3 + 1), 8'($urandom_range(0, 255)), 1 + k % 3, 3'b000, 3'b000, 1'b1,
                g, st, sd, p, gl);
        chk("served before reset", 32'(served_count), 32'd5);
        @(negedge clk);
        req = 3'b100; bag_data = 8'h07;
        for (int i = 0; i < 20 && !scan_start; i++) @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        chk("pre-reset busy in scan", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid reset outputs",
            32'({grant, scan_start, scan_data, busy, parity, starve_flag, served_count, timeout_err}),
            32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic; 256 completions must wrap served_count
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(3'($urandom_range(1, 7)), 8'($urandom_range(0, 255)), $urandom_range(1, 4),
                3'($urandom_range(0, 7)), 3'b000, 1'b1, g, st, sd, p, gl);
            if (k == 255) chk("served at 255", 32'(served_count), 32'd255);
        end
        chk("served wrap", 32'(served_count), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
